// File: rtl/rvvi_trace_packetizer.sv
// rvvi_trace_packetizer
//   Buffers retirement records from the core's retire stage in a small FIFO
//   and serializes each one into a framed packet of 64-bit words for the host
//   RVVI trace decoder. Word order is header, PC, instruction, then the GPR
//   data word and the CSR data word only when those writes are present.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   in_valid / in_ready        retirement record handshake
//   in_hart, in_trap, in_pc, in_insn, in_gpr_*, in_csr_*   record fields
//   out_valid / out_ready      packet word handshake
//   out_data, out_last         packet word, final-word marker
//   seq_num                    sequence number of the next packet to be sent
module rvvi_trace_packetizer #(
  parameter int XLEN      = 64,
  parameter int DEPTH     = 4,
  parameter int HART_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [HART_BITS-1:0] in_hart,
  input  logic                 in_trap,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_insn,
  input  logic                 in_gpr_wen,
  input  logic [4:0]           in_gpr_idx,
  input  logic [XLEN-1:0]      in_gpr_data,
  input  logic                 in_csr_wen,
  input  logic [11:0]          in_csr_idx,
  input  logic [XLEN-1:0]      in_csr_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic                 out_last,
  output logic [15:0]          seq_num
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Record as stored: data already zero-extended, write flags already
  // reduced to their effective values (x0 writes dropped).
  typedef struct packed {
    logic [HART_BITS-1:0] hart;
    logic                 trap;
    logic [63:0]          pc;
    logic [31:0]          insn;
    logic                 g;
    logic [4:0]           gidx;
    logic [63:0]          gdata;
    logic                 c;
    logic [11:0]          cidx;
    logic [63:0]          cdata;
  } rec_t;

  typedef enum logic [2:0] {IDLE, HDR, PC, INS, GPR, CSR} state_t;

  // ---------------------------------------------------------------- FIFO
  rec_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic          in_ready_q;
  logic          push, pop;
  rec_t          wr_rec;

  always_comb begin
    wr_rec       = '0;
    wr_rec.hart  = in_hart;
    wr_rec.trap  = in_trap;
    wr_rec.pc    = 64'(in_pc);
    wr_rec.insn  = in_insn;
    wr_rec.g     = in_gpr_wen && (in_gpr_idx != 5'd0);
    wr_rec.gidx  = wr_rec.g ? in_gpr_idx : 5'd0;
    wr_rec.gdata = 64'(in_gpr_data);
    wr_rec.c     = in_csr_wen;
    wr_rec.cidx  = in_csr_wen ? in_csr_idx : 12'd0;
    wr_rec.cdata = 64'(in_csr_data);
  end

  // in_ready_q is low whenever the FIFO is full, so a full FIFO never takes a
  // push even when the packet in flight pops in the same cycle.
  assign push     = in_valid && in_ready_q;
  assign in_ready = in_ready_q;
  assign count_n  = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_rec;
  end

  // ---------------------------------------------------------------- packetizer
  state_t      state, state_n;
  rec_t        cur, cur_n, src;
  logic [15:0] seq_q, seq_n;
  logic        load, eop;
  logic [63:0] word_n;
  logic        last_n;
  logic        out_valid_q, out_last_q;
  logic [63:0] out_data_q;
  logic        fire;

  assign fire = out_valid_q && out_ready;

  function automatic logic [63:0] header(input rec_t r, input logic [15:0] s);
    return {8'hA5, (r.trap ? 8'h02 : 8'h01), 8'(r.hart),
            4'd3 + {3'b0, r.g} + {3'b0, r.c}, r.g, r.c,
            r.gidx, r.cidx, 1'b0, s};
  endfunction

  always_comb begin
    state_n = state;
    seq_n   = seq_q;
    load    = 1'b0;
    eop     = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: if (count != '0) begin
        state_n = HDR;
        load    = 1'b1;
      end
      HDR: if (fire) state_n = PC;
      PC:  if (fire) state_n = INS;
      INS: if (fire) begin
        if (cur.g)      state_n = GPR;
        else if (cur.c) state_n = CSR;
        else            eop     = 1'b1;
      end
      GPR: if (fire) begin
        if (cur.c) state_n = CSR;
        else       eop     = 1'b1;
      end
      CSR: if (fire) eop = 1'b1;
      default: state_n = IDLE;
    endcase

    // End of packet: the head record is retired; chain straight into the
    // next header when another record is already buffered behind it.
    if (eop) begin
      pop   = 1'b1;
      seq_n = seq_q + 16'd1;
      if (count > CW'(1)) begin
        state_n = HDR;
        load    = 1'b1;
      end else begin
        state_n = IDLE;
      end
    end
  end

  // The record being packetized is the FIFO head; at end of packet the head
  // is about to be popped, so the next one sits one slot further on.
  assign src   = eop ? mem[rd_ptr + AW'(1)] : mem[rd_ptr];
  assign cur_n = load ? src : cur;

  // Output word is registered and computed from the next state, so it is
  // stable for as long as the state does not advance.
  always_comb begin
    word_n = '0;
    last_n = 1'b0;
    case (state_n)
      HDR: word_n = header(cur_n, seq_n);
      PC:  word_n = cur_n.pc;
      INS: begin
        word_n = {32'b0, cur_n.insn};
        last_n = !cur_n.g && !cur_n.c;
      end
      GPR: begin
        word_n = cur_n.gdata;
        last_n = !cur_n.c;
      end
      CSR: begin
        word_n = cur_n.cdata;
        last_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cur         <= '0;
      seq_q       <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state       <= state_n;
      cur         <= cur_n;
      if (eop) seq_q <= seq_n;
      count       <= count_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      in_ready_q  <= (count_n != CW'(DEPTH));
      out_valid_q <= (state_n != IDLE);
      out_data_q  <= word_n;
      out_last_q  <= last_n;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign seq_num   = seq_q;

endmodule

// File: tb/tb_rvvi_trace_packetizer.sv
// Directed bench for rvvi_trace_packetizer: hand-computed packet words for
// minimal, full, x0/trap, GPR-only and CSR-only records, backpressure,
// FIFO-full, sequence wrap and mid-packet reset.
module tb_rvvi_trace_packetizer;
  localparam int XLEN = 64;
  localparam int DEPTH = 4;
  localparam int HB = 3;

  logic            clk, reset;
  logic            in_valid, in_ready;
  logic [HB-1:0]   in_hart;
  logic            in_trap;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_insn;
  logic            in_gpr_wen;
  logic [4:0]      in_gpr_idx;
  logic [XLEN-1:0] in_gpr_data;
  logic            in_csr_wen;
  logic [11:0]     in_csr_idx;
  logic [XLEN-1:0] in_csr_data;
  logic            out_valid, out_ready, out_last;
  logic [63:0]     out_data;
  logic [15:0]     seq_num;

  int n_chk = 0;
  int n_err = 0;

  rvvi_trace_packetizer #(.XLEN(XLEN), .DEPTH(DEPTH), .HART_BITS(HB)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_hart(in_hart),
    .in_trap(in_trap), .in_pc(in_pc), .in_insn(in_insn),
    .in_gpr_wen(in_gpr_wen), .in_gpr_idx(in_gpr_idx), .in_gpr_data(in_gpr_data),
    .in_csr_wen(in_csr_wen), .in_csr_idx(in_csr_idx), .in_csr_data(in_csr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .seq_num(seq_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one record from a negedge and returns at the negedge after the
  // accepting clock edge.
  task automatic push(input logic [HB-1:0] hart, input logic trap,
                      input logic [63:0] pc, input logic [31:0] insn,
                      input logic gw, input logic [4:0] gi, input logic [63:0] gd,
                      input logic cw, input logic [11:0] ci, input logic [63:0] cd);
    int n = 0;
    @(negedge clk);
    in_hart = hart; in_trap = trap; in_pc = pc; in_insn = insn;
    in_gpr_wen = gw; in_gpr_idx = gi; in_gpr_data = gd;
    in_csr_wen = cw; in_csr_idx = ci; in_csr_data = cd;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Samples the current word at a negedge (waiting if needed), then steps to
  // the next negedge; with out_ready=1 the word is taken in between.
  task automatic get_word(output logic [63:0] d, output logic l, output int waited);
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) chk("word_timeout", {63'b0, out_valid}, 64'd1);
    d = out_data;
    l = out_last;
    @(negedge clk);
  endtask

  task automatic expect_pkt(input string tag, input int nw,
                            input logic [63:0] w0, input logic [63:0] w1,
                            input logic [63:0] w2, input logic [63:0] w3,
                            input logic [63:0] w4, output int wsum);
    logic [63:0] e [5];
    logic [63:0] d;
    logic        l;
    int          wt;
    e = '{w0, w1, w2, w3, w4};
    wsum = 0;
    for (int k = 0; k < nw; k++) begin
      get_word(d, l, wt);
      wsum += wt;
      chk($sformatf("%s_w%0d", tag, k), d, e[k]);
      chk($sformatf("%s_last%0d", tag, k), {63'b0, l}, {63'b0, (k == nw - 1)});
    end
  endtask

  initial begin
    int          ws, acc, idle_seen;
    logic [63:0] q [$];
    logic        ql [$];
    logic [63:0] held_d;
    logic        held_l, stalled, done;

    reset = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    in_hart = '0; in_trap = 0; in_pc = '0; in_insn = '0;
    in_gpr_wen = 0; in_gpr_idx = '0; in_gpr_data = '0;
    in_csr_wen = 0; in_csr_idx = '0; in_csr_data = '0;

    // Reset state
    #12;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_last", {63'b0, out_last}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_seq", {48'b0, seq_num}, 64'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", {63'b0, in_ready}, 64'd1);

    // Minimal retire, seq 0; header one cycle after the acceptance cycle's next
    push(3'd0, 0, 64'h8000_0000, 32'h0000_0013, 0, 5'd0, 0, 0, 12'd0, 0);
    chk("lat_n1_valid", {63'b0, out_valid}, 64'd0);
    expect_pkt("min", 3, 64'hA501_0030_0000_0000, 64'h0000_0000_8000_0000,
               64'h13, 0, 0, ws);
    chk("lat_wait", ws, 64'd1);
    chk("min_seq", {48'b0, seq_num}, 64'd1);
    chk("min_idle", {63'b0, out_valid}, 64'd0);

    // Full record, seq 1
    push(3'd2, 0, 64'h8000_0004, 32'h0000_0293, 1, 5'd5, 64'hDEAD, 1, 12'h300, 64'h1888);
    expect_pkt("full", 5, 64'hA501_025C_A600_0001, 64'h8000_0004, 64'h293,
               64'hDEAD, 64'h1888, ws);

    // Trap with x0 write, seq 2
    push(3'd0, 1, 64'h8000_0008, 32'h0000_0073, 1, 5'd0, 64'h77, 0, 12'd0, 0);
    expect_pkt("trapx0", 3, 64'hA502_0030_0000_0002, 64'h8000_0008, 64'h73, 0, 0, ws);

    // Trap, GPR only, hart 7, seq 3
    push(3'd7, 1, 64'h8000_000C, 32'h0000_00B3, 1, 5'd1, 64'h55, 0, 12'd0, 0);
    expect_pkt("gpronly", 4, 64'hA502_0748_2000_0003, 64'h8000_000C, 64'hB3,
               64'h55, 0, ws);

    // CSR only, seq 4
    push(3'd0, 0, 64'h8000_0010, 32'h3410_1073, 0, 5'd3, 64'h99, 1, 12'h341, 64'h4242);
    expect_pkt("csronly", 4, 64'hA501_0044_0682_0004, 64'h8000_0010, 64'h3410_1073,
               64'h4242, 0, ws);

    // Backpressure, seq 5: out_ready pattern 1,0,0,1 repeating
    out_ready = 1'b0;
    push(3'd1, 0, 64'hFFFF_FFFF_0000_1000, 32'hABCD_0001, 1, 5'd31, 64'h1234,
         1, 12'hFFF, 64'h5678);
    stalled = 0; done = 0; held_d = '0; held_l = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (stalled) begin
        chk("bp_hold_valid", {63'b0, out_valid}, 64'd1);
        chk("bp_hold_data", out_data, held_d);
        chk("bp_hold_last", {63'b0, out_last}, {63'b0, held_l});
      end
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      if (out_valid && out_ready) begin
        q.push_back(out_data);
        ql.push_back(out_last);
        if (out_last) done = 1;
      end
      stalled = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("bp_nwords", q.size(), 64'd5);
    begin
      logic [63:0] bpe [5];
      bpe = '{64'hA501_015F_FFFE_0005, 64'hFFFF_FFFF_0000_1000, 64'hABCD_0001,
              64'h1234, 64'h5678};
      for (int k = 0; k < 5 && k < q.size(); k++) begin
        chk($sformatf("bp_w%0d", k), q[k], bpe[k]);
        chk($sformatf("bp_last%0d", k), {63'b0, ql[k]}, {63'b0, (k == 4)});
      end
    end

    // FIFO full: DEPTH accepts with the sink stalled, then the extra one blocks
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      push(3'd0, 0, 64'h2000 + 64'(k * 4), 32'h100 + 32'(k), 0, 5'd0, 0, 0, 12'd0, 0);
    @(negedge clk);
    in_valid = 1'b1;
    chk("full_in_ready", {63'b0, in_ready}, 64'd0);
    repeat (3) @(negedge clk);
    chk("full_in_ready_hold", {63'b0, in_ready}, 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < DEPTH; k++) begin
      expect_pkt($sformatf("fifo%0d", k), 3, 64'hA501_0030_0000_0006 + 64'(k),
                 64'h2000 + 64'(k * 4), 64'h100 + 64'(k), 0, 0, ws);
      acc += ws;
    end
    chk("fifo_no_bubble", acc, 64'd0);
    chk("fifo_seq", {48'b0, seq_num}, 64'd10);

    // Sequence wrap: counter preloaded to 0xFFFF while idle
    force dut.seq_q = 16'hFFFF;
    @(negedge clk);
    release dut.seq_q;
    @(negedge clk);
    chk("wrap_preload", {48'b0, seq_num}, 64'hFFFF);
    out_ready = 1'b0;
    push(3'd0, 0, 64'h3000, 32'h13, 0, 5'd0, 0, 0, 12'd0, 0);
    push(3'd0, 0, 64'h3004, 32'h13, 0, 5'd0, 0, 0, 12'd0, 0);
    out_ready = 1'b1;
    expect_pkt("wrapA", 3, 64'hA501_0030_0000_FFFF, 64'h3000, 64'h13, 0, 0, ws);
    expect_pkt("wrapB", 3, 64'hA501_0030_0000_0000, 64'h3004, 64'h13, 0, 0, ws);
    chk("wrap_seq", {48'b0, seq_num}, 64'd1);

    // Reset after the PC word with records still buffered
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      push(3'd0, 0, 64'h4000 + 64'(k * 4), 32'h13, 0, 5'd0, 0, 0, 12'd0, 0);
    out_ready = 1'b1;
    begin
      logic [63:0] d;
      logic        l;
      int          wt;
      get_word(d, l, wt);
      chk("mid_hdr", d, 64'hA501_0030_0000_0001);
      get_word(d, l, wt);
      chk("mid_pc", d, 64'h4000);
    end
    #1 reset = 1'b1;
    #1;
    chk("mid_out_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_out_data", out_data, 64'd0);
    chk("mid_out_last", {63'b0, out_last}, 64'd0);
    chk("mid_seq", {48'b0, seq_num}, 64'd0);
    chk("mid_in_ready", {63'b0, in_ready}, 64'd0);
    @(negedge clk); reset = 1'b0;
    idle_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) idle_seen++;
    end
    chk("post_rst_empty", idle_seen, 64'd0);
    chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
    push(3'd0, 0, 64'h5000, 32'h13, 0, 5'd0, 0, 0, 12'd0, 0);
    expect_pkt("post_rst", 3, 64'hA501_0030_0000_0000, 64'h5000, 64'h13, 0, 0, ws);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rvvi_trace_packetizer.md
Name: rvvi_trace_packetizer

Overview:
- DUT-side transmitter for the RVVI retirement stream consumed by the host trace decoder, which replays each packet as GPR-set/CSR-set/retire-or-trap calls.
- Accepts one retirement record per handshake from the core's retire stage and buffers it in a record FIFO.
- Serializes each record into a framed packet of 64-bit words on a valid/ready stream toward the host transport.

Parameters:
- XLEN, 64, architectural register width; 32 or 64 only. 32 zero-extends PC and data to 64 bits.
- DEPTH, 4, record FIFO depth; power of two, ≥2.
- HART_BITS, 3, hart id width; ≤8.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  retirement record valid.
- in_ready  output  1  record accepted when in_valid&&in_ready.
- in_hart  input  HART_BITS  hart id.
- in_trap  input  1  1=trap, 0=normal retire.
- in_pc  input  XLEN  retired PC.
- in_insn  input  32  instruction binary.
- in_gpr_wen  input  1  GPR written.
- in_gpr_idx  input  5  GPR index.
- in_gpr_data  input  XLEN  GPR value.
- in_csr_wen  input  1  CSR written.
- in_csr_idx  input  12  CSR index.
- in_csr_data  input  XLEN  CSR value.
- out_valid  output  1  word valid.
- out_ready  input  1  sink accepts word.
- out_data  output  64  packet word.
- out_last  output  1  final word of packet.
- seq_num  output  16  sequence number of next packet to be sent.

Behaviour:
- Reset values: in_ready=0 while reset is asserted, 1 on the first cycle after release. out_valid=0, out_last=0, out_data=0, seq_num=0, FIFO empty, FSM IDLE.
- Reset mid-packet clears outputs immediately (asynchronous). The partial packet and all buffered records are discarded.
- FIFO:
  - in_ready = !full, registered from occupancy.
  - When full, no push occurs even if a pop happens in the same cycle.
  - A push and a pop in the same cycle when not full leaves occupancy unchanged.
  - Records are captured whole on handshake.
- Effective GPR flag g = in_gpr_wen && (in_gpr_idx!=0). Effective CSR flag c = in_csr_wen.
- Packet words, in this order:
  - H header:
    - [63:56]=8'hA5
    - [55:48]=8'h02 if trap, else 8'h01
    - [47:40]=hart id, zero-extended
    - [39:36]=word count, 3+g+c
    - [35]=g, [34]=c
    - [33:29]=gpr_idx (0 if !g)
    - [28:17]=csr_idx (0 if !c)
    - [16]=0
    - [15:0]=seq_num
  - P: PC, zero-extended.
  - I: {32'b0, insn}.
  - G: GPR data, present only if g.
  - C: CSR data, present only if c.
- FSM states: IDLE, HDR, PC, INS, GPR, CSR.
  - IDLE → HDR when FIFO non-empty; the head record is latched into the output register.
  - Each state advances only on out_valid&&out_ready.
  - INS → GPR if g, else → CSR if c, else end of packet. GPR → CSR if c, else end of packet.
  - End of packet: pop the FIFO and increment seq_num mod 2^16 (0xFFFF → 0x0000). Go to HDR directly if another record is buffered (no idle bubble), else IDLE.
- out_last=1 exactly on the final word.
- Stability: while out_valid && !out_ready, out_data and out_last hold stable and out_valid stays 1.
- Latency: a record accepted in cycle N into an empty FIFO with FSM IDLE presents its header with out_valid=1 in cycle N+2.
- Sustained throughput: one word per cycle while out_ready=1.
- Trap records are packetized identically apart from the type field.

Test Plan:
- Minimal retire: single retire, pc=0x8000_0000, insn=0x0000_0013, no writes, out_ready=1 → 3 words.
  - H=0xA501_0030_0000_0000, then 0x0000_0000_8000_0000, then 0x13; out_last on word 3; seq_num becomes 1.
- Full record: in_hart=2, gpr x5=0xDEAD, csr 0x300=0x1888 → 5 words.
  - Header count=5, [35:34]=2'b11, gpr_idx=5, csr_idx=0x300; G=0xDEAD, then C=0x1888.
- x0 write and trap: in_gpr_wen=1 with idx 0, plus a trap record → 3-word packet, type 0x02, bit35=0.
- Backpressure: out_ready toggles 1,0,0,1 during a packet → no word lost or duplicated, out_data stable while stalled.
  - Push DEPTH+1 records with out_ready=0 → in_ready=0 after DEPTH accepts; all DEPTH packets emitted in order afterwards.
- seq_num wrap: preload by sending 65535 packets → next header seq field=0xFFFF, following header 0x0000.
- Reset mid-packet: assert reset after the PC word → out_valid=0 immediately.
  - After release, seq_num=0, FIFO empty; the next record's header has seq field 0.
